// File: rtl/fdma_wr_arbiter_n_if.sv
// Bundle of requester-side and FDMA-side signals for the N-channel write arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface fdma_wr_arbiter_n_if #(
    parameter int CH_NUM         = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 23
);
    logic [CH_NUM*AXI_ADDR_WIDTH-1:0] ch_waddr;
    logic [CH_NUM-1:0]                ch_wareq;
    logic [CH_NUM*16-1:0]             ch_wsize;
    logic [CH_NUM-1:0]                ch_wbusy;
    logic [CH_NUM*AXI_DATA_WIDTH-1:0] ch_wdata;
    logic [CH_NUM-1:0]                ch_wvalid;
    logic [AXI_ADDR_WIDTH-1:0]        fdma_waddr;
    logic                             fdma_wareq;
    logic [15:0]                      fdma_wsize;
    logic                             fdma_wbusy;
    logic                             fdma_wvalid;
    logic [AXI_DATA_WIDTH-1:0]        fdma_wdata;
    logic [CH_NUM-1:0]                grant;
    logic                             err_timeout;

    modport master (
        input  ch_waddr, ch_wareq, ch_wsize, ch_wdata, fdma_wbusy, fdma_wvalid,
        output ch_wbusy, ch_wvalid, fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata,
        output grant, err_timeout
    );

    modport slave (
        output ch_waddr, ch_wareq, ch_wsize, ch_wdata, fdma_wbusy, fdma_wvalid,
        input  ch_wbusy, ch_wvalid, fdma_waddr, fdma_wareq, fdma_wsize, fdma_wdata,
        input  grant, err_timeout
    );
endinterface

// File: rtl/fdma_wr_arbiter_n.sv
// Round-robin arbiter multiplexing CH_NUM write requesters onto one FDMA write port.
// Optional REQ-phase watchdog compiled in with `define FDMA_ARB_WATCHDOG_EN.
module fdma_wr_arbiter_n #(
    parameter int CH_NUM         = 4,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 23,
    parameter int TIMEOUT        = 1024
) (
    input  logic                ui_clk,
    input  logic                ui_rstn,
    fdma_wr_arbiter_n_if.master bus
);
    localparam int IDX_W = $clog2(CH_NUM);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;

    // Reset value makes channel 0 the first candidate after reset.
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(CH_NUM - 1);
    localparam logic [IDX_W:0]   CH_NUM_W  = (IDX_W+1)'(CH_NUM);
    localparam logic [CH_NUM-1:0] ONE_HOT0 = CH_NUM'(1);

    logic [1:0]                r_state;
    logic [CH_NUM-1:0]         r_grant;
    logic [AXI_ADDR_WIDTH-1:0] r_waddr;
    logic [15:0]               r_wsize;
    logic                      r_wareq;
    logic [IDX_W-1:0]          r_win_idx;
    logic [IDX_W-1:0]          r_last_grant;

    logic [CH_NUM-1:0]         w_eligible;
    logic [AXI_ADDR_WIDTH-1:0] w_addr_arr [CH_NUM];
    logic [15:0]               w_size_arr [CH_NUM];
    logic [AXI_DATA_WIDTH-1:0] w_data_arr [CH_NUM];

    logic                      w_found;
    logic [IDX_W-1:0]          w_win_idx;
    logic [AXI_DATA_WIDTH-1:0] w_wdata;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_slice
        assign w_addr_arr[g] = bus.ch_waddr[g*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        assign w_size_arr[g] = bus.ch_wsize[g*16 +: 16];
        assign w_data_arr[g] = bus.ch_wdata[g*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        assign w_eligible[g] = bus.ch_wareq[g] && (w_size_arr[g] != 16'd0);
    end

    // Search starts just after the previous owner and wraps modulo CH_NUM.
    always_comb begin
        logic [IDX_W:0] sum;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_found   = 1'b0;
        w_win_idx = '0;
        sum       = '0;
        for (int k = 1; k <= CH_NUM; k++) begin
            sum = {1'b0, r_last_grant} + (IDX_W+1)'(k);
            if (sum >= CH_NUM_W) sum = sum - CH_NUM_W;
            if (!w_found && w_eligible[sum[IDX_W-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = sum[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (r_grant[i]) w_wdata = w_wdata | w_data_arr[i];
        end
    end

`ifdef FDMA_ARB_WATCHDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_err_timeout;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ui_clk or negedge ui_rstn) begin
        if (!ui_rstn) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_waddr      <= '0;
            r_wsize      <= '0;
            r_wareq      <= 1'b0;
            r_win_idx    <= '0;
            r_last_grant <= LAST_RST;
`ifdef FDMA_ARB_WATCHDOG_EN
            r_wd_cnt      <= '0;
            r_err_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant   <= ONE_HOT0 << w_win_idx;
                        r_waddr   <= w_addr_arr[w_win_idx];
                        r_wsize   <= w_size_arr[w_win_idx];
                        r_wareq   <= 1'b1;
                        r_win_idx <= w_win_idx;
                        r_state   <= S_REQ;
`ifdef FDMA_ARB_WATCHDOG_EN
                        r_wd_cnt  <= '0;
`endif
                    end
                end
                S_REQ: begin
                    if (bus.fdma_wbusy) begin
                        r_wareq <= 1'b0;
                        r_state <= S_BUSY;
                    end
`ifdef FDMA_ARB_WATCHDOG_EN
                    // FDMA never accepted: give up, flag it, and let the next channel in.
                    else if (r_wd_cnt == WD_LAST) begin
                        r_wareq       <= 1'b0;
                        r_err_timeout <= 1'b1;
                        r_last_grant  <= r_win_idx;
                        r_grant       <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
`endif
                end
                S_BUSY: begin
                    if (!bus.fdma_wbusy) begin
                        r_last_grant <= r_win_idx;
                        r_grant      <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FDMA_ARB_WATCHDOG_EN
    assign bus.err_timeout = r_err_timeout;
`else
    assign bus.err_timeout = 1'b0;
`endif

    assign bus.grant      = r_grant;
    assign bus.fdma_waddr = r_waddr;
    assign bus.fdma_wsize = r_wsize;
    assign bus.fdma_wareq = r_wareq;
    assign bus.fdma_wdata = w_wdata;
    assign bus.ch_wbusy   = r_grant & {CH_NUM{bus.fdma_wbusy}};
    assign bus.ch_wvalid  = r_grant & {CH_NUM{bus.fdma_wvalid}};
endmodule

// File: tb/tb_fdma_wr_arbiter_n.sv
// Self-checking bench for fdma_wr_arbiter_n: vector table plus hand-written
// reset, back-to-back round-robin and REQ-timeout sequences, with a grant scoreboard.
module tb_fdma_wr_arbiter_n;
    localparam int CH = 4;
    localparam int DW = 32;
    localparam int AW = 23;
`ifdef FDMA_ARB_WATCHDOG_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif
    localparam int WAIT_MAX = 64;

    logic ui_clk  = 1'b0;
    logic ui_rstn = 1'b1;
    always #5 ui_clk = ~ui_clk;

    fdma_wr_arbiter_n_if #(.CH_NUM(CH), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) bus ();

    fdma_wr_arbiter_n #(
        .CH_NUM(CH), .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .TIMEOUT(TO)
    ) dut (
        .ui_clk (ui_clk),
        .ui_rstn(ui_rstn),
        .bus    (bus.master)
    );

    typedef struct {
        int              ch;
        logic [AW-1:0]   addr;
        logic [15:0]     size;
    } exp_t;

    typedef struct {
        logic [CH-1:0] req;
        logic [CH-1:0] zero;
        int            exp_ch;
    } vec_t;

    exp_t          exp_q[$];
    vec_t          vecs[8];
    logic [AW-1:0] ch_addr[CH];
    logic [15:0]   ch_size[CH];
    logic [DW-1:0] ch_data[CH];
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int ch);
        exp_t e;
        e.ch   = ch;
        e.addr = ch_addr[ch];
        e.size = ch_size[ch];
        return e;
    endfunction

    task automatic apply_req(input logic [CH-1:0] req, input logic [CH-1:0] zero);
        for (int i = 0; i < CH; i++) begin
            bus.ch_waddr[i*AW +: AW] = ch_addr[i];
            bus.ch_wsize[i*16 +: 16] = zero[i] ? 16'd0 : ch_size[i];
            bus.ch_wdata[i*DW +: DW] = ch_data[i];
        end
        bus.ch_wareq = req;
    endtask

    task automatic wait_wareq(output int cycles);
        cycles = 0;
        while (!bus.fdma_wareq && cycles < WAIT_MAX) begin
            @(negedge ui_clk);
            cycles++;
        end
    endtask

    // Acts as the FDMA engine for one burst and checks the arbiter around it.
    task automatic serve(input int beats, input bit drop_req);
        exp_t          e;
        int            c;
        int            pulses;
        int            bad;
        logic [CH-1:0] oh;
        wait_wareq(c);
        check("wareq_wait_bound", c < WAIT_MAX, 1);
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() == 0) return;
        e  = exp_q.pop_front();
        oh = CH'(1) << e.ch;
        check("grant", bus.grant, oh);
        check("fdma_waddr", bus.fdma_waddr, e.addr);
        check("fdma_wsize", bus.fdma_wsize, e.size);
        if (drop_req) bus.ch_wareq = '0;
        @(negedge ui_clk);
        check("wareq_hold", bus.fdma_wareq, 1);
        bus.fdma_wbusy = 1'b1;
        @(negedge ui_clk);
        check("wareq_drop", bus.fdma_wareq, 0);
        pulses = 0;
        bad    = 0;
        for (int b = 0; b < beats; b++) begin
            bus.fdma_wvalid = 1'b1;
            #1;
            if (bus.ch_wvalid == oh) pulses++;
            if (bus.ch_wvalid != oh || bus.ch_wbusy != oh || bus.fdma_wdata != ch_data[e.ch]) bad++;
            @(negedge ui_clk);
        end
        check("wvalid_pulses", pulses, beats);
        check("beat_errors", bad, 0);
        bus.fdma_wvalid = 1'b0;
        bus.fdma_wbusy  = 1'b0;
        @(negedge ui_clk);
        check("grant_cleared", bus.grant, 0);
        check("wdata_idle_zero", bus.fdma_wdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit reached");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int c;
        int n;
        ch_addr = '{23'h100, 23'h200, 23'h400, 23'h800};
        ch_size = '{16'd64, 16'd128, 16'd256, 16'd64};
        ch_data = '{32'hA0A0_0000, 32'hB1B1_1111, 32'hC2C2_2222, 32'hD3D3_3333};
        vecs[0] = '{4'b0100, 4'b0000, 2};
        vecs[1] = '{4'b1111, 4'b0000, 3};
        vecs[2] = '{4'b0011, 4'b0000, 0};
        vecs[3] = '{4'b1001, 4'b0001, 3};
        vecs[4] = '{4'b0001, 4'b0000, 0};
        vecs[5] = '{4'b0101, 4'b0000, 2};
        vecs[6] = '{4'b0011, 4'b0000, 0};
        vecs[7] = '{4'b1010, 4'b1000, 1};

        apply_req('0, '0);
        bus.fdma_wbusy  = 1'b0;
        bus.fdma_wvalid = 1'b0;
        #2 ui_rstn = 1'b0;
        #1;
        check("rst_grant", bus.grant, 0);
        check("rst_wareq", bus.fdma_wareq, 0);
        check("rst_waddr", bus.fdma_waddr, 0);
        check("rst_wsize", bus.fdma_wsize, 0);
        check("rst_err", bus.err_timeout, 0);
        repeat (2) @(negedge ui_clk);
        ui_rstn = 1'b1;
        @(negedge ui_clk);
        check("idle_no_req_wareq", bus.fdma_wareq, 0);

        for (int v = 0; v < 8; v++) begin
            apply_req(vecs[v].req, vecs[v].zero);
            exp_q.push_back(mk(vecs[v].exp_ch));
            serve(3, 1'b1);
        end

        // Reset while channel 1 is mid-burst.
        apply_req(4'b0010, '0);
        wait_wareq(c);
        check("pre_rst_grant", bus.grant, 4'b0010);
        bus.fdma_wbusy = 1'b1;
        @(negedge ui_clk);
        bus.fdma_wvalid = 1'b1;
        #1;
        check("pre_rst_wvalid", bus.ch_wvalid, 4'b0010);
        #1 ui_rstn = 1'b0;
        #1;
        check("async_rst_grant", bus.grant, 0);
        check("async_rst_wareq", bus.fdma_wareq, 0);
        check("async_rst_waddr", bus.fdma_waddr, 0);
        check("async_rst_wvalid", bus.ch_wvalid, 0);
        check("async_rst_wbusy", bus.ch_wbusy, 0);
        check("async_rst_wdata", bus.fdma_wdata, 0);
        repeat (2) @(negedge ui_clk);
        bus.fdma_wbusy  = 1'b0;
        bus.fdma_wvalid = 1'b0;
        apply_req(4'b1111, '0);
        ui_rstn = 1'b1;

        // Continuous requests: 0,1,2,3,0 with a single idle cycle between bursts.
        foreach (exp_q[i]) check("sb_drained", exp_q.size(), 0);
        exp_q.push_back(mk(0));
        exp_q.push_back(mk(1));
        exp_q.push_back(mk(2));
        exp_q.push_back(mk(3));
        exp_q.push_back(mk(0));
        for (int i = 0; i < 5; i++) begin
            serve((i == 1) ? 256 : 3, i == 4);
            if (i < 4) begin
                wait_wareq(c);
                check("one_idle_gap", c, 1);
            end
        end
        check("sb_empty_end", exp_q.size(), 0);

        // last owner is channel 0, so channel 1 wins next.
        apply_req(4'b0011, '0);
        exp_q.push_back(mk(1));
`ifdef FDMA_ARB_WATCHDOG_EN
        void'(exp_q.pop_back());
        wait_wareq(c);
        check("wd_first_grant", bus.grant, 4'b0010);
        n = 0;
        while (bus.fdma_wareq && n < 100) begin
            n++;
            @(negedge ui_clk);
        end
        check("wd_req_cycles", n, TO);
        check("wd_err_set", bus.err_timeout, 1);
        check("wd_grant_cleared", bus.grant, 0);
        wait_wareq(c);
        check("wd_gap", c, 1);
        exp_q.push_back(mk(0));
        serve(2, 1'b1);
        check("wd_err_sticky", bus.err_timeout, 1);
`else
        wait_wareq(c);
        n = 0;
        repeat (40) begin
            @(negedge ui_clk);
            if (bus.fdma_wareq && bus.err_timeout == 1'b0) n++;
        end
        check("no_wd_req_waits", n, 40);
        serve(2, 1'b1);
        check("no_wd_err_zero", bus.err_timeout, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
